mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master memory port arbiter: round-robin grant, one access per transaction,
// fixed slave read latency, read data captured per master.
module mem_port_arbiter #(
  parameter int LENGTH  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [LENGTH-1:0] m0_addr,
  input  logic [LENGTH-1:0] m1_addr,
  input  logic [LENGTH-1:0] m0_wdata,
  input  logic [LENGTH-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic [LENGTH-1:0] m0_rdata,
  output logic [LENGTH-1:0] m1_rdata,
  output logic              HSEL,
  output logic              HWRITE,
  output logic [LENGTH-1:0] HADDR,
  output logic [LENGTH-1:0] HWDATA,
  input  logic [LENGTH-1:0] HRDATA,
  output logic              busy
);

  // state  | meaning
  // IDLE   | no owner; requests sampled and arbitrated
  // ACCESS | one-cycle slave select with the owner's latched command
  // WAIT   | MEM_LAT cycles of slave latency; read data captured on exit
  // DONE   | one-cycle completion pulse to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} arbStateT;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  arbStateT    state, stateNext;
  logic [2:0]  waitCnt, waitCntNext;
  logic        owner, ownerNext;
  logic        lastOwner;
  logic        ownerWe;
  logic        grantNow;
  logic        winner;
  logic        selWe;
  logic [LENGTH-1:0] selAddr, selWdata;
  logic        captureRead;

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    grantNow    = 1'b0;
    winner      = owner;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          stateNext = ACCESS;
          grantNow  = 1'b1;
          // on contention the master that did not go last wins
          if (m0_req && m1_req) winner = ~lastOwner;
          else                  winner = m1_req;
        end
      end
      ACCESS: begin
        stateNext   = WAIT;
        waitCntNext = LAT;
      end
      WAIT: begin
        if (waitCnt <= 3'd1) begin
          stateNext   = DONE;
          waitCntNext = 3'd0;
        end else begin
          waitCntNext = waitCnt - 3'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    ownerNext   = grantNow ? winner : owner;
    selWe       = winner ? m1_we    : m0_we;
    selAddr     = winner ? m1_addr  : m0_addr;
    selWdata    = winner ? m1_wdata : m0_wdata;
    captureRead = (state == WAIT) && (stateNext == DONE) && !ownerWe;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      waitCnt <= 3'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner     <= 1'b0;
      lastOwner <= 1'b1;
      ownerWe   <= 1'b0;
      HADDR     <= '0;
      HWDATA    <= '0;
      HSEL      <= 1'b0;
      HWRITE    <= 1'b0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      busy      <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      if (grantNow) begin
        owner     <= winner;
        lastOwner <= winner;
        ownerWe   <= selWe;
        HADDR     <= selAddr;
        HWDATA    <= selWdata;
      end
      HSEL    <= grantNow;
      HWRITE  <= grantNow && selWe;
      m0_gnt  <= (stateNext != IDLE) && !ownerNext;
      m1_gnt  <= (stateNext != IDLE) && ownerNext;
      m0_done <= (stateNext == DONE) && !owner;
      m1_done <= (stateNext == DONE) && owner;
      busy    <= (stateNext != IDLE);
      if (captureRead) begin
        if (owner) m1_rdata <= HRDATA;
        else       m0_rdata <= HRDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_port_arbiter;

  typedef struct {
    logic        master;
    logic [31:0] rdata;
    int          cyc;
  } expT;

  logic clock = 1'b0;
  logic reset;
  logic m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic m0_gnt, m1_gnt, m0_done, m1_done, HSEL, HWRITE, busy;
  logic [31:0] m0_rdata, m1_rdata, HADDR, HWDATA, HRDATA;

  logic l3Req;
  logic [31:0] l3Addr;
  logic l3Zero = 1'b0;
  logic [31:0] l3ZeroW = 32'h0;
  logic l3M0Gnt, l3M1Gnt, l3M0Done, l3M1Done, l3Hsel, l3Hwrite, l3Busy;
  logic [31:0] l3M0Rdata, l3M1Rdata, l3Haddr, l3Hwdata;

  logic [31:0] dataBase = 32'h0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  expT q[$];
  expT q3[$];
  logic [31:0] mRd0, mRd1;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // slave model: read data changes every cycle so capture timing is observable
  assign HRDATA = dataBase + 32'(cyc);

  mem_port_arbiter #(.LENGTH(32), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .HSEL(HSEL), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .busy(busy)
  );

  mem_port_arbiter #(.LENGTH(32), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .m0_req(l3Req), .m1_req(l3Zero), .m0_we(l3Zero), .m1_we(l3Zero),
    .m0_addr(l3Addr), .m1_addr(l3ZeroW), .m0_wdata(l3ZeroW), .m1_wdata(l3ZeroW),
    .m0_gnt(l3M0Gnt), .m1_gnt(l3M1Gnt), .m0_done(l3M0Done), .m1_done(l3M1Done),
    .m0_rdata(l3M0Rdata), .m1_rdata(l3M1Rdata),
    .HSEL(l3Hsel), .HWRITE(l3Hwrite), .HADDR(l3Haddr), .HWDATA(l3Hwdata), .HRDATA(HRDATA),
    .busy(l3Busy)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input logic master, input logic [31:0] rdata, input int doneCyc);
    expT e;
    e.master = master;
    e.rdata  = rdata;
    e.cyc    = doneCyc;
    q.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // completion monitor, MEM_LAT=1 instance
  always @(negedge clock) begin
    expT e;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checkVal("done_missing", 64'(cyc), 64'(q[0].cyc));
      void'(q.pop_front());
    end
    if (m0_done || m1_done) begin
      checkVal("done_both", 64'(m0_done & m1_done), 64'(0));
      if (q.size() == 0) begin
        checkVal("done_unexpected", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        checkVal("done_master", 64'(m1_done), 64'(e.master));
        checkVal("done_cycle", 64'(cyc), 64'(e.cyc));
        checkVal("done_rdata", 64'(m1_done ? m1_rdata : m0_rdata), 64'(e.rdata));
      end
    end
  end

  // completion monitor, MEM_LAT=3 instance
  always @(negedge clock) begin
    expT e;
    if (q3.size() > 0 && q3[0].cyc < cyc) begin
      checkVal("lat3_done_missing", 64'(cyc), 64'(q3[0].cyc));
      void'(q3.pop_front());
    end
    if (l3M0Done || l3M1Done) begin
      if (q3.size() == 0) begin
        checkVal("lat3_done_unexpected", 64'(1), 64'(0));
      end else begin
        e = q3.pop_front();
        checkVal("lat3_done_master", 64'(l3M1Done), 64'(e.master));
        checkVal("lat3_done_cycle", 64'(cyc), 64'(e.cyc));
        checkVal("lat3_done_rdata", 64'(l3M0Rdata), 64'(e.rdata));
      end
    end
  end

  initial begin
    int c0;
    expT e3;
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    l3Req = 1'b0; l3Addr = '0;
    mRd0 = '0; mRd1 = '0;

    // reset values
    waitCycles(2);
    checkVal("rst_ctrl", 64'({HSEL, HWRITE, m0_gnt, m1_gnt, m0_done, m1_done, busy}), 64'(0));
    checkVal("rst_haddr", 64'(HADDR), 64'(0));
    checkVal("rst_hwdata", 64'(HWDATA), 64'(0));
    checkVal("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'(0));
    checkVal("rst_lat3", 64'({l3Hsel, l3Busy, l3M0Gnt, l3Haddr}), 64'(0));
    reset = 1'b1;

    // m0 read, request and address disturbed after grant
    @(negedge clock);
    c0 = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0040_0000;
    dataBase = 32'h1234_5678 - 32'(c0 + 2);
    mRd0 = 32'h1234_5678;
    pushExp(1'b0, mRd0, c0 + 3);
    @(negedge clock);
    checkVal("rd_access_hsel", 64'(HSEL), 64'(1));
    checkVal("rd_access_hwrite", 64'(HWRITE), 64'(0));
    checkVal("rd_access_haddr", 64'(HADDR), 64'(32'h0040_0000));
    checkVal("rd_access_gnt", 64'({m1_gnt, m0_gnt, busy}), 64'(3'b011));
    m0_req = 1'b0; m0_addr = 32'hFFFF_FFF0;
    @(negedge clock);
    checkVal("rd_wait_hsel", 64'(HSEL), 64'(0));
    checkVal("rd_wait_haddr", 64'(HADDR), 64'(32'h0040_0000));
    checkVal("rd_wait_gnt", 64'({m1_gnt, m0_gnt}), 64'(2'b01));
    @(negedge clock);
    checkVal("rd_done_pulse", 64'({m1_done, m0_done}), 64'(2'b01));
    @(negedge clock);
    checkVal("rd_idle", 64'({busy, m0_gnt, m1_gnt, m0_done}), 64'(0));

    // m1 write leaves m1_rdata unchanged
    c0 = cyc;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0010; m1_wdata = 32'hDEAD_BEEF;
    pushExp(1'b1, mRd1, c0 + 3);
    @(negedge clock);
    checkVal("wr_access_ctrl", 64'({HSEL, HWRITE}), 64'(2'b11));
    checkVal("wr_access_hwdata", 64'(HWDATA), 64'(32'hDEAD_BEEF));
    checkVal("wr_access_haddr", 64'(HADDR), 64'(32'h0000_0010));
    checkVal("wr_access_gnt", 64'({m1_gnt, m0_gnt}), 64'(2'b10));
    m1_req = 1'b0;
    @(negedge clock);
    checkVal("wr_wait_hwrite", 64'(HWRITE), 64'(0));
    @(negedge clock);
    checkVal("wr_done_m0_quiet", 64'(m0_done), 64'(0));
    waitCycles(1);

    // round robin from a fresh reset with both masters requesting
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mRd0 = '0; mRd1 = '0;
    c0 = cyc;
    dataBase = 32'hC0DE_0000;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0A00;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0B00;
    pushExp(1'b0, dataBase + 32'(c0 + 2), c0 + 3);
    pushExp(1'b1, dataBase + 32'(c0 + 6), c0 + 7);
    pushExp(1'b0, dataBase + 32'(c0 + 10), c0 + 11);
    mRd0 = dataBase + 32'(c0 + 10);
    mRd1 = dataBase + 32'(c0 + 6);
    @(negedge clock);
    checkVal("rr_first_gnt", 64'({m1_gnt, m0_gnt}), 64'(2'b01));
    waitCycles(3);
    checkVal("rr_idle_gap", 64'({busy, HSEL}), 64'(0));
    @(negedge clock);
    checkVal("rr_second_gnt", 64'({m1_gnt, m0_gnt}), 64'(2'b10));
    checkVal("rr_second_haddr", 64'(HADDR), 64'(32'h0000_0B00));
    waitCycles(4);
    checkVal("rr_third_gnt", 64'({m1_gnt, m0_gnt, HSEL}), 64'(3'b011));
    m0_req = 1'b0; m1_req = 1'b0;
    waitCycles(3);
    checkVal("rr_end_idle", 64'(busy), 64'(0));

    // reset during WAIT abandons the transaction; m1 held across release
    c0 = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
    m1_we = 1'b0; m1_addr = 32'h0000_0200;
    @(negedge clock);
    m0_req = 1'b0; m1_req = 1'b1;
    @(negedge clock);
    checkVal("rstmid_in_wait", 64'({busy, m0_gnt}), 64'(2'b11));
    reset = 1'b0;
    #1;
    checkVal("rstmid_ctrl", 64'({HSEL, HWRITE, m0_gnt, m1_gnt, m0_done, m1_done, busy}), 64'(0));
    checkVal("rstmid_data", 64'({HADDR, m0_rdata}), 64'(0));
    mRd0 = '0; mRd1 = '0;
    @(negedge clock);
    checkVal("rstmid_held", 64'(busy), 64'(0));
    reset = 1'b1;
    c0 = cyc;
    mRd1 = dataBase + 32'(c0 + 2);
    pushExp(1'b1, mRd1, c0 + 3);
    @(negedge clock);
    checkVal("rstmid_m1_access", 64'({m1_gnt, m0_gnt, HSEL}), 64'(3'b101));
    checkVal("rstmid_m1_haddr", 64'(HADDR), 64'(32'h0000_0200));
    m1_req = 1'b0;
    waitCycles(3);

    // MEM_LAT=3 instance: three WAIT cycles, data from the last one
    c0 = cyc;
    dataBase = 32'h5A00_0000;
    l3Req = 1'b1; l3Addr = 32'h0000_0300;
    e3.master = 1'b0;
    e3.rdata  = dataBase + 32'(c0 + 4);
    e3.cyc    = c0 + 5;
    q3.push_back(e3);
    @(negedge clock);
    checkVal("lat3_access", 64'({l3Hsel, l3M0Gnt, l3Busy}), 64'(3'b111));
    checkVal("lat3_haddr", 64'(l3Haddr), 64'(32'h0000_0300));
    l3Req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkVal($sformatf("lat3_wait%0d", i), 64'({l3Hsel, l3M0Done, l3M0Gnt, l3Busy}), 64'(4'b0011));
    end
    @(negedge clock);
    checkVal("lat3_quiet_m1", 64'({l3M1Gnt, l3M1Done, l3Hwrite, l3M1Rdata, l3Hwdata}), 64'(0));
    @(negedge clock);
    checkVal("lat3_idle", 64'(l3Busy), 64'(0));

    waitCycles(2);
    checkVal("sb_empty", 64'(q.size()), 64'(0));
    checkVal("sb3_empty", 64'(q3.size()), 64'(0));
    checkVal("final_rdata_m0", 64'(m0_rdata), 64'(mRd0));
    checkVal("final_rdata_m1", 64'(m1_rdata), 64'(mRd1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
